// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO write sink.
package gpio_pkg;
   localparam int GPIO_ADDR_W = 32;
   localparam int GPIO_DATA_W = 8;
   localparam logic [31:0] GPIO_BASE_ADDR = 32'h0000_0400;
   localparam int GPIO_WINDOW_SIZE = 256;
   localparam int OVF_CNT_W = 16;

   typedef struct packed {
      logic [GPIO_ADDR_W-1:0] addr;
      logic [GPIO_DATA_W-1:0] data;
   } gpio_wr_t;

   function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, extra-MSB pointers; head visible combinationally (1-cycle write-to-read).
// Push while full is accepted only together with a pop; storage itself is not reset.
module sync_fifo #(
   parameter int  DEPTH = 16,
   parameter type T     = logic [7:0]
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  T                       wr,
   input  logic                   pop,
   output T                       rd,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);

   T               mem [DEPTH];
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   // Gate the head so the output reads zero whenever nothing is stored.
   assign rd      = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end
endmodule

// File: rtl/gpio_sink.sv
// Captures core GPIO writes into a FIFO and hands them out over valid/ready; 1-cycle latency.
// Writes arriving while full without a pop are dropped and counted. Filter: GPIO_SINK_ADDR_FILTER_EN.
module gpio_sink
   import gpio_pkg::*;
#(
   parameter int                DEPTH       = 16,
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(GPIO_BASE_ADDR),
   parameter int                WINDOW_SIZE = GPIO_WINDOW_SIZE
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_W-1:0]      GPIOaddr,
   input  logic [DATA_W-1:0]      GPIO,
   input  logic                   GPIOEn,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ADDR_W-1:0]      out_addr,
   output logic [DATA_W-1:0]      out_data,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   output logic [OVF_CNT_W-1:0]   ovf_count,
   input  logic                   ovf_clr
);
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

`ifdef GPIO_SINK_ADDR_FILTER_EN
   localparam bit FILTER_EN = 1'b1;
`else
   localparam bit FILTER_EN = 1'b0;
`endif

   // One extra bit so the window end cannot wrap at the top of the address space.
   localparam logic [ADDR_W:0] WIN_LO = (ADDR_W+1)'(BASE_ADDR);
   localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(WINDOW_SIZE);

   entry_t wr_ent;
   entry_t rd_ent;
   logic   in_window;
   logic   push_req;
   logic   pop;
   logic   drop;
   logic   fifo_full;
   logic   fifo_empty;

   assign in_window = ({1'b0, GPIOaddr} >= WIN_LO) && ({1'b0, GPIOaddr} < WIN_HI);
   assign push_req  = GPIOEn && (in_window || !FILTER_EN);
   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign drop      = push_req && fifo_full && !pop;
   assign wr_ent    = '{addr: GPIOaddr, data: GPIO};
   assign out_addr  = rd_ent.addr;
   assign out_data  = rd_ent.data;

   sync_fifo #(
      .DEPTH (DEPTH),
      .T     (entry_t)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .wr    (wr_ent),
      .pop   (pop),
      .rd    (rd_ent),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   // Clear takes priority, but a drop in the same cycle is still recorded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         ovf_count <= '0;
      end else if (ovf_clr) begin
         overflow  <= drop;
         ovf_count <= drop ? OVF_CNT_W'(1) : '0;
      end else if (drop) begin
         overflow  <= 1'b1;
         ovf_count <= sat_inc(ovf_count);
      end
   end
endmodule

// File: tb/tb_gpio_sink.sv
// Directed bench for gpio_sink with hand-computed expectations.
module tb_gpio_sink;
   import gpio_pkg::*;

   logic        clk;
   logic        rst;
   logic [31:0] GPIOaddr;
   logic [7:0]  GPIO;
   logic        GPIOEn;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_addr;
   logic [7:0]  out_data;
   logic [4:0]  level;
   logic        overflow;
   logic [15:0] ovf_count;
   logic        ovf_clr;

   int n_checks = 0;
   int n_pass   = 0;

   gpio_sink dut (
      .clk       (clk),
      .rst       (rst),
      .GPIOaddr  (GPIOaddr),
      .GPIO      (GPIO),
      .GPIOEn    (GPIOEn),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_data  (out_data),
      .level     (level),
      .overflow  (overflow),
      .ovf_count (ovf_count),
      .ovf_clr   (ovf_clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [31:0] a, input logic [7:0] d);
      GPIOEn   = 1'b1;
      GPIOaddr = a;
      GPIO     = d;
      tick();
      GPIOEn   = 1'b0;
      GPIOaddr = 32'hDEAD_BEEF;
      GPIO     = 8'hEE;
   endtask

   initial begin
      rst = 1'b1; GPIOaddr = '0; GPIO = '0; GPIOEn = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
      tick(); tick();
      check("rst_valid", out_valid, 0);
      check("rst_level", level, 0);
      check("rst_overflow", overflow, 0);
      check("rst_ovf_count", ovf_count, 0);
      check("rst_addr", out_addr, 0);
      check("rst_data", out_data, 0);
      rst = 1'b0;
      tick();

      // single write, held while not ready
      write(32'h400, 8'hA5);
      check("single_valid", out_valid, 1);
      check("single_head", {out_addr, out_data}, {32'h400, 8'hA5});
      check("single_level", level, 1);
      tick(); tick();
      check("single_hold_valid", out_valid, 1);
      check("single_hold_head", {out_addr, out_data}, {32'h400, 8'hA5});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("single_pop_valid", out_valid, 0);
      check("single_pop_level", level, 0);

      // 18 writes into a 16-deep FIFO
      for (int i = 0; i < 18; i++) write(32'h410 + i, 8'(i));
      check("fill_level", level, 16);
      check("fill_overflow", overflow, 1);
      check("fill_ovf_count", ovf_count, 2);
      check("fill_head", {out_addr, out_data}, {32'h410, 8'h00});

      // full: push and pop together
      out_ready = 1'b1;
      write(32'h4F0, 8'h77);
      check("fullpp_level", level, 16);
      check("fullpp_ovf_count", ovf_count, 2);
      for (int i = 0; i < 16; i++) begin
         logic [39:0] exp;
         exp = (i < 15) ? {32'h411 + 32'(i), 8'(i + 1)} : {32'h4F0, 8'h77};
         check("drain_valid", out_valid, 1);
         check("drain_head", {out_addr, out_data}, exp);
         tick();
      end
      out_ready = 1'b0;
      check("drain_empty", out_valid, 0);
      check("drain_level", level, 0);

      // clear, then build ovf_count to 5, then clear plus drop
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      check("clr_count", ovf_count, 0);
      check("clr_overflow", overflow, 0);
      for (int i = 0; i < 21; i++) write(32'h400 + i, 8'(i));
      check("five_count", ovf_count, 5);
      ovf_clr = 1'b1;
      write(32'h4AA, 8'h55);
      ovf_clr = 1'b0;
      check("clrdrop_count", ovf_count, 1);
      check("clrdrop_overflow", overflow, 1);

      // saturation
      GPIOEn = 1'b1; GPIOaddr = 32'h401;
      repeat (65540) tick();
      GPIOEn = 1'b0;
      check("sat_count", ovf_count, 16'hFFFF);
      check("sat_level", level, 16);
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      check("sat_clr_count", ovf_count, 0);
      check("sat_clr_overflow", overflow, 0);

      // asynchronous reset with 8 entries held
      out_ready = 1'b1;
      repeat (8) tick();
      out_ready = 1'b0;
      check("mid_level", level, 8);
      check("mid_head", {out_addr, out_data}, {32'h408, 8'h08});
      #3 rst = 1'b1;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_level", level, 0);
      GPIOEn = 1'b1; GPIOaddr = 32'h420; GPIO = 8'h11;
      tick(); tick();
      GPIOEn = 1'b0;
      rst = 1'b0;
      tick();
      check("arst_writes_lost", level, 0);
      check("arst_not_counted", ovf_count, 0);

      // streaming: push into empty with ready high, then one-in one-out
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         GPIOEn = 1'b1; GPIOaddr = 32'h480 + i; GPIO = 8'hC0 + 8'(i);
         tick();
         check("stream_valid", out_valid, 1);
         check("stream_head", {out_addr, out_data}, {32'h480 + 32'(i), 8'hC0 + 8'(i)});
         check("stream_level", level, 1);
      end
      GPIOEn = 1'b0;
      tick();
      out_ready = 1'b0;
      check("stream_end_valid", out_valid, 0);
      check("stream_end_level", level, 0);

`ifdef GPIO_SINK_ADDR_FILTER_EN
      write(32'h3FF, 8'h01);
      write(32'h400, 8'h02);
      write(32'h4FF, 8'h03);
      write(32'h500, 8'h04);
      check("filt_level", level, 2);
      check("filt_head0", {out_addr, out_data}, {32'h400, 8'h02});
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      check("filt_head1", {out_addr, out_data}, {32'h4FF, 8'h03});
      check("filt_ovf", ovf_count, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/gpio_sink.md
# gpio_sink

Receiving end of the processor's GPIO write port. Every cycle in which the core asserts `GPIOEn`, the block captures the `{GPIOaddr, GPIO}` write into an internal FIFO. It then hands entries to a downstream peripheral (display, LED or UART driver) over a valid/ready handshake. The FIFO decouples the core's one-write-per-cycle burst rate from slower consumers and reports dropped writes.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `ADDR_W`, 32: captured address width.
- `DATA_W`, 8: captured data width.
- `BASE_ADDR`, 32'h0000_0400: window base; used only with the filter macro.
- `WINDOW_SIZE`, 256: window length in words; used only with the filter macro.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `GPIOaddr` in ADDR_W: write address from the core.
- `GPIO` in DATA_W: write data from the core.
- `GPIOEn` in 1: write strobe; one write per cycle while high.
- `out_valid` out 1: head entry available.
- `out_ready` in 1: consumer accepts head entry.
- `out_addr` out ADDR_W: head entry address.
- `out_data` out DATA_W: head entry data.
- `level` out $clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky, set when a write is dropped.
- `ovf_count` out 16: dropped-write counter; saturates at 16'hFFFF.
- `ovf_clr` in 1: synchronous clear of `overflow` and `ovf_count`.

## Operation
- Push: `GPIOEn` is high and the write is accepted (full rules below). `{GPIOaddr, GPIO}` is written at the write pointer.
- Pop: `out_valid && out_ready`. The read pointer advances and the next entry appears the following cycle.
- Pointers are $clog2(DEPTH)+1 bits wide.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the low bits are equal.
  - Pointers wrap naturally modulo 2·DEPTH.
- Full with push and pop in the same cycle: both occur, `level` is unchanged, nothing is dropped.
- Full with push and no pop: the write is dropped, `overflow` is set, and `ovf_count` increments (saturating).
- Empty with push and `out_ready` high: the entry is stored. It is not bypassed; `out_valid` rises the next cycle.
- `ovf_clr` and a drop in the same cycle: the clear wins, then the counter is loaded with 1 and `overflow` is set. The new event is not lost.
- `out_addr` and `out_data` are stable while `out_valid` is high and `out_ready` is low. Their values are don't-care while `out_valid` is low.
- `out_valid` never drops without a pop.

## Timing
- Reset values (asynchronous):
  - `out_valid`=0, `level`=0, `overflow`=0, `ovf_count`=0.
  - Pointers = 0, `out_addr`/`out_data`=0.
  - FIFO storage is not reset.
- Write-to-valid latency: 1 cycle. A push at edge N gives `out_valid` high after edge N.
- Throughput: one push and one pop per cycle sustained.
- `level` is registered and reflects the pushes and pops of the previous edge.
- `rst` asserted mid-burst empties the FIFO immediately, with no handshake completion. Writes presented during reset are lost and are not counted.

## Configuration
- `GPIO_SINK_ADDR_FILTER_EN` defined:
  - A write is pushed only if `BASE_ADDR ≤ GPIOaddr < BASE_ADDR+WINDOW_SIZE`.
  - Out-of-window writes are ignored silently; they are never counted as overflow.
- Not defined: every `GPIOEn` write is a push candidate, and `BASE_ADDR`/`WINDOW_SIZE` are unused.

## Structure
- Shared package `gpio_pkg`:
  - `gpio_wr_t` struct `{addr, data}`.
  - Default `BASE_ADDR`/`WINDOW_SIZE` constants.
  - Counter width constant (16).
- Sub-module `sync_fifo`: parameterised depth and entry type, with push/pop/full/empty/level.
- `gpio_sink` contains the address filter, the drop logic, the overflow counter and the handshake glue.

## Test plan
- Single write: `GPIOEn`=1, addr 0x400, data 0xA5 for one cycle, `out_ready`=0. Required: `out_valid`=1 the next cycle with 0x400/0xA5 held stable; `level`=1.
- Fill and overflow: 18 consecutive writes with `out_ready`=0, DEPTH=16. Required: `level`=16, `overflow`=1, `ovf_count`=2, and the head still holds the first write.
- Full with simultaneous push and pop: FIFO full and `out_ready`=1 while writing 0x77. Required: `level` stays 16, `ovf_count` unchanged, and 0x77 is read out last.
- Clear plus drop in the same cycle: `ovf_count`=5, then `ovf_clr` together with a dropped write. Required: `ovf_count`=1, `overflow`=1.
- Reset mid-burst: 8 entries held, `rst` pulsed asynchronously between edges. Required: `out_valid`=0 and `level`=0 immediately.
- Filter (macro defined): writes to 0x3FF, 0x400, 0x4FF and 0x500. Required: only 0x400 and 0x4FF are delivered, `ovf_count`=0.
